clk_div_checker: RTL and testbench

CLK_DIV_CHECKER -- requirements
Module: clk_div_checker

---
 rtl/clk_div_checker.sv | 160 ++++++++++++++++
 tb/tb_clk_div_checker.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_checker.sv
// Checks that a divided clock runs at RATIO t_clk cycles per period, then reports lock, sticky error and error count.
// Optional duty-cycle check: define CLK_CHK_DUTY_EN.
module clk_div_checker #(
   parameter int RATIO    = 8,
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4
) (
   input  logic             t_clk,
   input  logic             rst_n,
   input  logic             div_clk_in,
   input  logic             enable,
   input  logic             err_clr,
   output logic             lock,
   output logic             err,
   output logic [7:0]       err_count,
   output logic [CNT_W-1:0] meas_period
);
   // state    | meaning
   // S_IDLE   | checking off; counters cleared, results held
   // S_ACQUIRE| waiting for the first rise to start a period
   // S_MEASURE| measuring periods, counting consecutive good ones
   // S_LOCKED | LOCK_CNT good periods seen; any bad one drops back

   // One spare bit so the timeout value 2*RATIO+1 fits even at the largest RATIO.
   localparam int CW = CNT_W + 1;
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0] RATIO_C = CW'(RATIO);
   localparam logic [CW-1:0] TO_C    = CW'(2 * RATIO);
   localparam logic [CW-1:0] HOLD_C  = CW'(2 * RATIO + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_MEASURE, S_LOCKED} state_t;

   state_t          state, nxt_state;
   logic            sync_q1, sync_q2, sync_q3, rise_q;
   logic [CW-1:0]   cnt;
   logic [GW-1:0]   good_cnt;
   logic            measuring, timeout, period_ok, good, bad;

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         sync_q3 <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q1 <= div_clk_in;
         sync_q2 <= sync_q1;
         sync_q3 <= sync_q2;
         rise_q  <= sync_q2 & ~sync_q3;
      end
   end

`ifdef CLK_CHK_DUTY_EN
   localparam logic [CW-1:0] HALF_C = CW'(RATIO / 2);
   logic            fall_q;
   logic [CW-1:0]   hi_cnt, hi_meas;

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         fall_q  <= 1'b0;
         hi_cnt  <= '0;
         hi_meas <= '0;
      end else begin
         fall_q <= ~sync_q2 & sync_q3;
         if (state == S_IDLE) begin
            hi_cnt  <= '0;
            hi_meas <= '0;
         end else if (rise_q) begin
            hi_cnt  <= CW'(1);
            hi_meas <= '0;
         end else begin
            if (hi_cnt != {CW{1'b1}})
               hi_cnt <= hi_cnt + CW'(1);
            if (fall_q)
               hi_meas <= hi_cnt;
         end
      end
   end

   assign period_ok = (cnt == RATIO_C) && (hi_meas == HALF_C);
`else
   assign period_ok = (cnt == RATIO_C);
`endif

   assign measuring = (state == S_MEASURE) || (state == S_LOCKED);
   assign timeout   = measuring && !rise_q && (cnt == TO_C);
   assign good      = measuring && rise_q && period_ok;
   assign bad       = (measuring && rise_q && !period_ok) || timeout;

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (state == S_IDLE)
         cnt <= '0;
      else if (rise_q)
         cnt <= CW'(1);
      else if (timeout)
         cnt <= HOLD_C;
      else if (measuring && cnt == HOLD_C)
         cnt <= cnt;
      else if (cnt != {CW{1'b1}})
         cnt <= cnt + CW'(1);
   end

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n)
         good_cnt <= '0;
      else if (state == S_IDLE || bad)
         good_cnt <= '0;
      else if (good && good_cnt != GW'(LOCK_CNT))
         good_cnt <= good_cnt + GW'(1);
   end

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         err         <= 1'b0;
         err_count   <= '0;
         meas_period <= '0;
      end else begin
         if (bad)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
         // A clear coinciding with a bad period leaves that one period counted.
         if (err_clr)
            err_count <= bad ? 8'd1 : 8'd0;
         else if (bad && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
         if (measuring && rise_q)
            meas_period <= cnt[CW-1] ? {CNT_W{1'b1}} : cnt[CNT_W-1:0];
      end
   end

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= nxt_state;
   end

   always_comb begin
      nxt_state = state;
      if (!enable)
         nxt_state = S_IDLE;
      else begin
         case (state)
            S_IDLE:    nxt_state = S_ACQUIRE;
            S_ACQUIRE: if (rise_q) nxt_state = S_MEASURE;
            S_MEASURE: if (good && good_cnt == GW'(LOCK_CNT - 1)) nxt_state = S_LOCKED;
            S_LOCKED:  if (bad) nxt_state = S_MEASURE;
            default:   nxt_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      lock = (state == S_LOCKED);
   end

endmodule

// File: tb/tb_clk_div_checker.sv
// Self-checking bench for clk_div_checker: a period-level reference model feeds an err_count scoreboard.
module tb_clk_div_checker;
   localparam int RATIO    = 8;
   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;

   logic             t_clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             div_clk_in = 1'b0;
   logic             enable = 1'b0;
   logic             err_clr = 1'b0;
   logic             lock, err;
   logic [7:0]       err_count;
   logic [CNT_W-1:0] meas_period;

   clk_div_checker #(.RATIO(RATIO), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) u_dut (
      .t_clk(t_clk), .rst_n(rst_n), .div_clk_in(div_clk_in), .enable(enable),
      .err_clr(err_clr), .lock(lock), .err(err), .err_count(err_count),
      .meas_period(meas_period)
   );

   always #5 t_clk = ~t_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // generator configuration, latched at the start of every period; period 0 = stuck low
   int gen_period = 8;
   int gen_high   = 4;
   bit clr_req    = 1'b0;
   int cur_len    = 0;
   int cur_high   = 0;
   int g_p, g_h;
   bit g_c;

   typedef enum {M_IDLE, M_ACQ, M_MEAS} mstate_t;
   mstate_t     m_state   = M_IDLE;
   int          m_good    = 0;
   int          m_err_cnt = 0;
   int          m_meas    = 0;
   bit          m_lock    = 1'b0;
   bit          m_err     = 1'b0;
   int unsigned sb_q[$];
   logic [7:0]  seen = 8'd0;
   int          cnt_before;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic set_cnt(input int v);
      if (v != m_err_cnt) sb_q.push_back(v);
      m_err_cnt = v;
   endtask

   task automatic model_bad(input bit clr);
      m_err  = 1'b1;
      m_good = 0;
      m_lock = 1'b0;
      set_cnt(clr ? 1 : (m_err_cnt < 255 ? m_err_cnt + 1 : 255));
   endtask

   task automatic model_rise(input int len, input int hi, input bit clr);
      bit ok;
      if (m_state == M_ACQ)
         m_state = M_MEAS;
      else if (m_state == M_MEAS) begin
         m_meas = (len > 2*RATIO) ? 2*RATIO + 1 : len;
         ok = (m_meas == RATIO);
`ifdef CLK_CHK_DUTY_EN
         ok = ok && (hi == RATIO/2);
`endif
         if (!ok) model_bad(clr);
         else begin
            if (clr) begin
               m_err = 1'b0;
               set_cnt(0);
            end
            m_good++;
            if (m_good >= LOCK_CNT) m_lock = 1'b1;
         end
      end
   endtask

   // divided-clock generator; every rise drives the reference model
   initial begin
      forever begin
         if (gen_period == 0) begin
            div_clk_in = 1'b0;
            @(negedge t_clk);
            cur_len++;
            if (cur_len == 2*RATIO + 1 && m_state == M_MEAS) model_bad(1'b0);
         end else begin
            g_p = gen_period;
            g_h = gen_high;
            g_c = clr_req;
            clr_req = 1'b0;
            model_rise(cur_len, cur_high, g_c);
            cur_len = 0;
            div_clk_in = 1'b1;
            if (g_c) begin
               fork
                  begin
                     repeat (3) @(negedge t_clk);
                     err_clr = 1'b1;
                     @(negedge t_clk);
                     err_clr = 1'b0;
                  end
               join_none
            end
            repeat (g_h) begin @(negedge t_clk); cur_len++; end
            cur_high = g_h;
            div_clk_in = 1'b0;
            repeat (g_p - g_h) begin @(negedge t_clk); cur_len++; end
         end
      end
   end

   // scoreboard: every change of err_count must match the next expected value
   initial begin
      forever begin
         @(posedge t_clk);
         #1;
         if (err_count !== seen) begin
            if (sb_q.size() == 0) check("sb_unexpected", err_count, seen);
            else check("sb_err_count", err_count, sb_q.pop_front());
            seen = err_count;
         end
      end
   end

   task automatic wait_div(input bit lvl);
      int n = 0;
      while (div_clk_in == lvl && n < 64) begin @(posedge t_clk); n++; end
      while (div_clk_in != lvl && n < 64) begin @(posedge t_clk); n++; end
      check("div_edge_wait", n < 64, 1);
   endtask

   // just past a rise, after the DUT has registered it and before the next one
   task automatic settle();
      wait_div(1'b1);
      repeat (4) @(negedge t_clk);
   endtask

   task automatic after_fall();
      wait_div(1'b0);
      @(negedge t_clk);
   endtask

   initial begin
      repeat (4) @(negedge t_clk);
      check("reset_lock", lock, 0);
      check("reset_err", err, 0);
      check("reset_err_count", err_count, 0);
      check("reset_meas", meas_period, 0);
      rst_n = 1'b1;

      after_fall();
      enable = 1'b1;
      m_state = M_ACQ;
      repeat (64) @(negedge t_clk);
      settle();
      check("clean_lock", lock, 1);
      check("clean_err", err, 0);
      check("clean_meas", meas_period, 8);
      check("clean_err_count", err_count, 0);

      gen_period = 6; gen_high = 3;
      repeat (60) @(negedge t_clk);
      settle();
      check("ratio_meas", meas_period, 6);
      check("ratio_lock", lock, 0);
      check("ratio_err", err, 1);
      check("ratio_err_count", err_count, m_err_cnt);

      begin
         int n = 0;
         clr_req = 1'b1;
         while (clr_req && n < 20) begin @(posedge t_clk); n++; end
         check("clr_wait", n < 20, 1);
         repeat (4) @(negedge t_clk);
         check("clr_err", err, 1);
         check("clr_err_count", err_count, 1);
      end

      gen_period = 8; gen_high = 4;
      repeat (72) @(negedge t_clk);
      settle();
      check("relock_lock", lock, 1);
      check("relock_meas", meas_period, 8);

      cnt_before = m_err_cnt;
      gen_period = 0;
      repeat (48) @(negedge t_clk);
      check("stuck_lock", lock, 0);
      check("stuck_err_count", err_count, cnt_before + 1);
      check("stuck_err", err, 1);
      check("stuck_meas", meas_period, 8);

      gen_high = 4; gen_period = 8;
      repeat (80) @(negedge t_clk);
      settle();
      check("resume_lock", lock, 1);
      check("resume_err_count", err_count, m_err_cnt);

      after_fall();
      set_cnt(0);
      m_err = 1'b0; m_meas = 0; m_lock = 1'b0; m_good = 0; m_state = M_IDLE;
      rst_n = 1'b0;
      @(negedge t_clk);
      check("rst_lock", lock, 0);
      check("rst_err", err, 0);
      check("rst_err_count", err_count, 0);
      check("rst_meas", meas_period, 0);
      @(negedge t_clk);
      rst_n = 1'b1;
      m_state = M_ACQ;
      repeat (64) @(negedge t_clk);
      settle();
      check("rst_relock_lock", lock, 1);
      check("rst_relock_err", err, 0);
      check("rst_relock_err_count", err_count, 0);
      check("rst_relock_meas", meas_period, 8);

      gen_high = 3;
      repeat (72) @(negedge t_clk);
      settle();
`ifdef CLK_CHK_DUTY_EN
      check("duty_err", err, 1);
      check("duty_lock", lock, 0);
`else
      check("duty_err", err, 0);
      check("duty_lock", lock, 1);
`endif
      check("duty_err_count", err_count, m_err_cnt);

      gen_period = 6; gen_high = 3;
      repeat (6*300 + 12) @(negedge t_clk);
      settle();
      check("sat_err_count", err_count, 255);
      check("sat_err", err, 1);

      after_fall();
      enable = 1'b0;
      m_state = M_IDLE; m_lock = 1'b0; m_good = 0;
      repeat (10) @(negedge t_clk);
      check("disable_lock", lock, 0);
      check("disable_err", err, 1);
      check("disable_err_count", err_count, 255);
      check("disable_meas", meas_period, 6);
      check("sb_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
